lut_loader: RTL and testbench

- Runtime writer for the single-port 32-bit coefficient LUTs in the range-limited force pipeline, e.g. the c1_8 table.
- Accepts a valid/ready stream of DEPTH coefficient words and writes them sequentially into the LUT through its address/data/wren port.
- Reads every entry back, compares an XOR checksum, then returns the LUT port to the force pipeline.
- When idle, the pipeline's read requests pass straight through to the LUT.

---
 rtl/lut_pkg.sv | 18 +
 rtl/lut_rd_tracker.sv | 54 +++++
 rtl/lut_loader.sv | 159 +++++++++++++++
 tb/tb_lut_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared definitions for the coefficient LUT loader and readback helpers.
package lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DRAIN  = 2'd3
    } lut_state_e;

    // Address register plus output register inside the LUT macro.
    localparam int LUT_RD_LATENCY = 2;

    localparam int DEF_DEPTH      = 3072;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/lut_rd_tracker.sv
// Latency-matched valid pipeline for LUT reads; folds each returning word
// into an XOR checksum and counts how many words have come back.
module lut_rd_tracker
    import lut_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_ADDR_WIDTH + 1,
    parameter int LATENCY    = LUT_RD_LATENCY
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] sum,
    output logic [CNT_WIDTH-1:0]  ret_cnt
);

    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    always_comb begin
        vld_d = (vld_q << 1) | LATENCY'(rd_issue);
        sum_d = sum_q;
        cnt_d = cnt_q;
        // The oldest stage lines up with the cycle rd_data is valid.
        if (vld_q[LATENCY-1]) begin
            sum_d = sum_q ^ rd_data;
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (clear) begin
            vld_d = '0;
            sum_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum     = sum_q;
    assign ret_cnt = cnt_q;

endmodule

// File: rtl/lut_loader.sv
// Runtime loader for a single-port coefficient LUT: stream in, write, read back,
// checksum. For a gap-free stream done rises on the 2*DEPTH+3'th clock edge
// after the edge that accepts the first word.
module lut_loader
    import lut_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] cli_address,
    input  logic                  cli_rden,
    output logic [DATA_WIDTH-1:0] cli_q,
    output logic [ADDR_WIDTH-1:0] lut_address,
    output logic [DATA_WIDTH-1:0] lut_data,
    output logic                  lut_rden,
    output logic                  lut_wren,
    input  logic [DATA_WIDTH-1:0] lut_q,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_err,
    output lut_state_e            dbg_state
);

    // in_data/in_valid/in_ready: a word transfers on every clock edge where
    // in_valid && in_ready; in_ready is high exactly while in LOAD.

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    lut_state_e            state_q, state_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0] wsum_q, wsum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  rden_q, rden_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  idle;
    logic                  trk_clear;
    logic [DATA_WIDTH-1:0] rsum;
    logic [CNT_W-1:0]      ret_cnt;

    assign idle = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wsum_d    = wsum_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        trk_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    wsum_d    = '0;
                    err_d     = 1'b0;
                    trk_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wren_d   = 1'b1;
                    addr_d   = wr_cnt_q[ADDR_WIDTH-1:0];
                    data_d   = in_data;
                    wsum_d   = wsum_q ^ in_data;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == LAST) state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                // The first read registers while the final write is on the port.
                rden_d   = 1'b1;
                addr_d   = rd_cnt_q[ADDR_WIDTH-1:0];
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ret_cnt == FULL) begin
                    done_d  = 1'b1;
                    err_d   = (rsum != wsum_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wsum_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wsum_q   <= wsum_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    lut_rd_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_W),
        .LATENCY    (LUT_RD_LATENCY)
    ) u_rd_tracker (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (trk_clear),
        .rd_issue (rden_q && !idle),
        .rd_data  (lut_q),
        .sum      (rsum),
        .ret_cnt  (ret_cnt)
    );

    // Client reads bypass the registers in IDLE so they see no extra latency.
    assign lut_address = idle ? cli_address : addr_q;
    assign lut_rden    = idle ? cli_rden : rden_q;
    assign lut_wren    = wren_q;
    assign lut_data    = data_q;
    assign cli_q       = lut_q;
    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = !idle;
    assign done        = done_q;
    assign verify_err  = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lut_loader.sv
// Scoreboard bench for lut_loader with a two-cycle-latency LUT model.
module tb_lut_loader;
    import lut_pkg::*;

    localparam int DEPTH = 3072;
    localparam int AW    = 12;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] cli_address = '0;
    logic          cli_rden = 1'b0;
    logic [DW-1:0] cli_q;
    logic [AW-1:0] lut_address;
    logic [DW-1:0] lut_data;
    logic          lut_rden;
    logic          lut_wren;
    logic [DW-1:0] lut_q;
    logic          busy;
    logic          done;
    logic          verify_err;
    lut_state_e    dbg_state;

    lut_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cli_address (cli_address),
        .cli_rden    (cli_rden),
        .cli_q       (cli_q),
        .lut_address (lut_address),
        .lut_data    (lut_data),
        .lut_rden    (lut_rden),
        .lut_wren    (lut_wren),
        .lut_q       (lut_q),
        .busy        (busy),
        .done        (done),
        .verify_err  (verify_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- LUT model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ra_q = '0;
    logic [DW-1:0] q_q = '0;
    logic          corrupt = 1'b0;

    always @(posedge clock) begin
        if (lut_wren) mem[lut_address] <= lut_data;
        if (lut_rden) ra_q <= lut_address;
        q_q <= mem[ra_q] ^ ((corrupt && busy && ra_q == AW'(7)) ? 32'h1 : 32'h0);
    end
    assign lut_q = q_q;

    // ---------------- scoreboard ----------------
    logic [AW+DW-1:0] exp_wr_q[$];
    logic             exp_err_q[$];
    logic [DW-1:0]    exp_cli_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_seen = 0;
    int   done_seen = 0;
    int   done_cyc = 0;
    int   iso_viol = 0;
    logic iso_watch = 1'b0;
    logic cli_v1 = 1'b0;
    logic cli_v2 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        cli_v1 <= cli_rden && !busy && rst_n && !iso_watch;
        cli_v2 <= cli_v1;
    end

    // Monitor: pops an expectation whenever the DUT presents a write, a done or client data.
    always @(negedge clock) begin
        logic [AW+DW-1:0] e;
        if (rst_n) begin
            if (lut_wren) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0h", lut_address, lut_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 64'(lut_address), 64'(e[AW+DW-1:DW]));
                    check("wr_data", 64'(lut_data), 64'(e[DW-1:0]));
                end
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'(0));
                if (exp_err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done verify_err=%0d", verify_err);
                end else begin
                    check("verify_err", 64'(verify_err), 64'(exp_err_q.pop_front()));
                end
            end
            if (cli_v2) begin
                if (exp_cli_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cli_read q=%0h", cli_q);
                end else begin
                    check("cli_q", 64'(cli_q), 64'(exp_cli_q.pop_front()));
                end
            end
            if (iso_watch && busy && lut_address == cli_address) iso_viol++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] word(input int pat, input int i);
        case (pat)
            0:       word = DW'(i * 3);
            1:       word = DW'(i) ^ 32'h5A5A_0000;
            default: word = 32'hC0DE_0000 + DW'(i * 7);
        endcase
    endfunction

    task automatic do_start(input logic exp_err);
        start = 1'b1;
        exp_err_q.push_back(exp_err);
        step();
        start = 1'b0;
        wr_seen   = 0;
        done_seen = 0;
    endtask

    task automatic send_words(input int n, input bit throttle, input int pat, output int first_cyc);
        first_cyc = 0;
        for (int i = 0; i < n; i++) begin
            int t;
            if (throttle && i > 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = word(pat, i);
            t = 0;
            while (!in_ready && t < 20) begin
                step();
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout word=%0d", i);
            end
            exp_wr_q.push_back({AW'(i), in_data});
            @(posedge clock);
            #1;
            if (i == 0) first_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_seen == 0 && t < 3 * DEPTH + 50) begin
            step();
            t++;
        end
        if (done_seen == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout waited=%0d cycles", t);
        end
        step();
    endtask

    task automatic cli_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        cli_address = addr;
        cli_rden    = 1'b1;
        #1;
        check("passthru_addr", 64'(lut_address), 64'(addr));
        check("passthru_rden", 64'(lut_rden), 64'(1));
        exp_cli_q.push_back(exp);
        step();
        cli_rden = 1'b0;
        repeat (3) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_wren", 64'(lut_wren), 64'(0));
        check("rst_rden", 64'(lut_rden), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_verify_err", 64'(verify_err), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a load
        do_start(1'b0);
        check("load_in_ready", 64'(in_ready), 64'(1));
        send_words(100, 1'b0, 2, fc);
        check("wren_before_reset", 64'(lut_wren), 64'(1));
        rst_n = 1'b0;
        #1;
        check("reset_mid_wren", 64'(lut_wren), 64'(0));
        check("reset_mid_busy", 64'(busy), 64'(0));
        check("reset_mid_in_ready", 64'(in_ready), 64'(0));
        exp_wr_q.delete();
        exp_err_q.delete();
        step();
        rst_n = 1'b1;
        step();

        // Gap-free full load, data = address*3
        do_start(1'b0);
        send_words(DEPTH, 1'b0, 0, fc);
        wait_done();
        check("gapfree_wr_count", 64'(wr_seen), 64'(DEPTH));
        check("gapfree_latency", 64'(done_cyc - fc), 64'(2 * DEPTH + 3));
        check("gapfree_wr_q_empty", 64'(exp_wr_q.size()), 64'(0));
        check("gapfree_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        cli_read(AW'(5), 32'd15);
        cli_read(AW'(DEPTH - 1), DW'((DEPTH - 1) * 3));

        // Throttled stream, valid toggling 1/0
        do_start(1'b0);
        send_words(DEPTH, 1'b1, 1, fc);
        wait_done();
        check("throttle_wr_count", 64'(wr_seen), 64'(DEPTH));
        check("throttle_wr_q_empty", 64'(exp_wr_q.size()), 64'(0));
        cli_read(AW'(5), 32'h5A5A_0005);

        // Corrupted readback at address 7
        corrupt = 1'b1;
        do_start(1'b1);
        send_words(DEPTH, 1'b0, 2, fc);
        wait_done();
        corrupt = 1'b0;
        check("corrupt_err_sticky", 64'(verify_err), 64'(1));

        // Busy isolation: start and cli_rden held through LOAD and VERIFY
        iso_watch   = 1'b1;
        cli_address = AW'(4000);
        cli_rden    = 1'b1;
        start       = 1'b1;
        exp_err_q.push_back(1'b0);
        step();
        wr_seen   = 0;
        done_seen = 0;
        check("start_clears_err", 64'(verify_err), 64'(0));
        check("iso_busy", 64'(busy), 64'(1));
        send_words(DEPTH, 1'b0, 0, fc);
        repeat (DEPTH / 2) step();
        check("iso_state_verify", 64'(dbg_state), 64'(ST_VERIFY));
        start    = 1'b0;
        cli_rden = 1'b0;
        wait_done();
        iso_watch = 1'b0;
        check("iso_no_cli_addr", 64'(iso_viol), 64'(0));
        check("iso_wr_count", 64'(wr_seen), 64'(DEPTH));
        repeat (4) step();
        check("iso_stays_idle", 64'(busy), 64'(0));
        cli_read(AW'(10), 32'd30);

        check("cli_q_empty", 64'(exp_cli_q.size()), 64'(0));
        check("err_q_empty", 64'(exp_err_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
